// File: rtl/spi_pkg.sv
// spi_pkg: shared types for the SPI initiator.
// FSM state encoding and bus idle levels.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_t;

  localparam logic SCK_IDLE = 1'b0;
  localparam logic SCE_IDLE = 1'b1;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period counter for SCK generation.
// Counts 0..CLK_DIV-1; o_tick marks the terminal count.
module spi_clk_div #(
  parameter int CLK_DIV  = 4,
  parameter int DIV_BITS = $clog2(CLK_DIV)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [DIV_BITS-1:0] LAST =
    DIV_BITS'(CLK_DIV - 1);

  logic [DIV_BITS-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign o_tick = (cnt == LAST) && !i_clr;

endmodule

// File: rtl/spi_master.sv
// spi_master: CPOL=0/CPHA=0 SPI initiator, MSB first, active-low CE.
// Define SPI_MASTER_BURST_EN to chain words under one CE assertion.
module spi_master
  import spi_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int CLK_DIV   = 4,
  parameter int DIV_BITS  = $clog2(CLK_DIV),
  parameter int WORD_BITS = $clog2(WORD_SIZE) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic                 o_sck,
  output logic                 o_sce,
  output logic                 o_sout,
  input  logic                 i_sin,
  input  logic [WORD_SIZE-1:0] i_win,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic [WORD_SIZE-1:0] o_wout,
  output logic                 o_wstb
);

  state_t state, state_d;

  logic                 tick;
  logic                 load;
  logic                 capture;
  logic                 done;
  logic                 last_bit;
  logic [WORD_SIZE-1:0] tx;
  logic [WORD_SIZE-1:0] rx;
  logic [WORD_BITS-1:0] bit_cnt;

  spi_clk_div #(
    .CLK_DIV  (CLK_DIV),
    .DIV_BITS (DIV_BITS)
  ) u_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (state == IDLE),
    .o_tick (tick)
  );

  assign last_bit = bit_cnt == WORD_BITS'(WORD_SIZE - 1);
  // MOSI is the MSB of the transmit register itself
  assign o_sout = tx[WORD_SIZE-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    capture = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          load    = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) state_d = HIGH;
      end
      HIGH: begin
        if (tick) begin
          capture = 1'b1;
          state_d = LOW;
        end
      end
      LOW: begin
        if (tick)
          state_d = (bit_cnt == WORD_BITS'(WORD_SIZE))
                    ? HOLD : HIGH;
      end
      HOLD: begin
        if (tick) begin
          done    = 1'b1;
          state_d = GAP;
`ifdef SPI_MASTER_BURST_EN
          if (i_start) begin
            load    = 1'b1;
            state_d = SETUP;
          end
`endif
        end
      end
      GAP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sck   <= SCK_IDLE;
      o_sce   <= SCE_IDLE;
      o_busy  <= 1'b0;
      o_wout  <= '0;
      o_wstb  <= 1'b0;
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
    end else begin
      o_sck  <= (state_d == HIGH) ? ~SCK_IDLE : SCK_IDLE;
      o_sce  <= (state_d inside {SETUP, HIGH, LOW, HOLD})
                ? ~SCE_IDLE : SCE_IDLE;
      o_busy <= state_d != IDLE;
      o_wstb <= done;
      if (done) o_wout <= rx;
      if (load) begin
        tx      <= i_win;
        rx      <= '0;
        bit_cnt <= '0;
      end else if (capture) begin
        rx      <= {rx[WORD_SIZE-2:0], i_sin};
        bit_cnt <= bit_cnt + 1'b1;
        if (!last_bit)
          tx <= {tx[WORD_SIZE-2:0], 1'b0};
      end
    end
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
SPI initiator for CPOL=0, CPHA=0 with active-low chip enable. It is the other end of the team's existing SPI slave and is used to read external converters and to drive slave ports in loopback tests. It shifts one WORD_SIZE-bit word out MSB-first on o_sout while capturing i_sin, then hands the received word back on a strobe. SCK is generated by dividing i_clk.

Parameters:
WORD_SIZE, 16, bits per transfer (>= 2)
CLK_DIV, 4, i_clk cycles per SCK half-period (>= 4 so a 2-FF-synchronised slave can respond)
DIV_BITS, $clog2(CLK_DIV), width of the half-period counter
WORD_BITS, $clog2(WORD_SIZE)+1, width of the bit counter

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; synchronous, active-high; clock is i_clk
o_sck  out  1  SPI clock, idle low
o_sce  out  1  chip enable, active low, idle high
o_sout  out  1  MOSI
i_sin  in  1  MISO
i_win  in  WORD_SIZE  word to transmit, sampled on accepted start
i_start  in  1  start request, one-cycle pulse or level
o_busy  out  1  high from the cycle after an accepted start until IDLE is re-entered
o_wout  out  WORD_SIZE  last received word, MSB first-received
o_wstb  out  1  one-cycle pulse when o_wout is updated

Behaviour:
- All outputs are registered. Reset values: o_sck=0, o_sce=1, o_sout=0, o_busy=0, o_wout=0, o_wstb=0. The state machine resets to IDLE.
- Reset asserted mid-transfer aborts the transfer immediately. On the next cycle all outputs hold their reset values, o_wout is cleared, and no strobe is issued.
- IDLE:
  - i_start=1 with o_busy=0 at cycle T latches i_win into the shift register.
  - At T+1: o_sce=0, o_busy=1, o_sout=i_win[MSB]. Go to SETUP.
  - i_start while o_busy=1 is ignored; no queuing.
- SETUP: CLK_DIV cycles with o_sck=0, then go to HIGH.
- HIGH:
  - o_sck=1 for CLK_DIV cycles.
  - i_sin is sampled on the last i_clk cycle of the phase, shifted into the receive register LSB-first-in.
  - The bit counter increments.
- LOW:
  - o_sck=0 for CLK_DIV cycles.
  - On the first cycle of the phase o_sout advances to the next bit.
  - After WORD_SIZE HIGH phases, go to HOLD instead of HIGH; o_sout holds the last bit.
- HOLD: CLK_DIV cycles with o_sce=0 and o_sck=0. On exit:
  - o_sce=1
  - o_wout=receive register
  - o_wstb=1 for exactly one cycle
  - go to GAP.
- GAP: CLK_DIV cycles with o_sce=1 and o_busy=1, guaranteeing minimum CE-high time. Then IDLE with o_busy=0.
- Timing:
  - Total busy length = CLK_DIV*(2*WORD_SIZE+3) cycles.
  - Exactly WORD_SIZE SCK rising edges per transfer.
  - o_sck never toggles while o_sce=1.
- A half-period counter runs 0..CLK_DIV-1 and produces a one-cycle tick at terminal count.
- The bit counter is WORD_BITS wide and counts 0..WORD_SIZE with no wrap; it is compared against WORD_SIZE.

Optional Feature:
SPI_MASTER_BURST_EN
- Defined: i_start=1 during the last HOLD cycle latches a new i_win. o_wstb still pulses for the completed word, but o_sce stays low and the FSM goes directly to SETUP for the next word, so back-to-back words share one CE assertion.
- Undefined: HOLD always exits to GAP and i_start there is ignored. There is no port difference between builds.

Decomposition:
- Package spi_pkg holds:
  - state enum: IDLE, SETUP, HIGH, LOW, HOLD, GAP
  - localparams for the SCK/CE idle levels (SCK_IDLE=0, SCE_IDLE=1)
- One natural sub-module: spi_clk_div, a half-period counter with parameter CLK_DIV, inputs i_clk, i_rst and i_clr (restart), output o_tick.
- Shifters and FSM stay in spi_master.

Test Plan:
- Reset, then idle 50 cycles -> o_sce=1, o_sck=0, o_busy=0, o_wout=0, o_wstb never high.
- Loopback o_sout->i_sin, CLK_DIV=4, i_win=0xA5C3, start -> 16 SCK rising edges, o_wout=0xA5C3, single o_wstb, o_busy high 4*35=140 cycles.
- Instance against spi_slave (WORD_SIZE=16) with slave i_win=0x1234, master i_win=0xBEEF -> master o_wout=0x1234, slave o_wout=0xBEEF, slave o_wstb once.
- i_start pulsed again at cycle 10 of a transfer -> ignored: one o_wstb only, SCK edge count 16, next start accepted only after o_busy falls.
- i_rst asserted after 7 SCK edges -> next cycle o_sce=1, o_sck=0, o_busy=0, no o_wstb; a following start transfers 0x0F0F correctly.
- With SPI_MASTER_BURST_EN, start 0x1111 then i_start held high through HOLD with i_win=0x2222 -> o_sce stays low across 32 SCK edges, two o_wstb pulses, loopback o_wout 0x1111 then 0x2222.
